// File: rtl/pattern_checker_if.sv
// Handshake and status bundle between the pattern generator/play logic and the checker.
// The slave modport is the checker side; master is the driving side.
interface pattern_checker_if #(
    parameter int WIDTH = 6,
    parameter int PTR_W = 3
);
    logic             pattern_valid;
    logic [WIDTH-1:0] pattern_in;
    logic             start;
    logic             guess_valid;
    logic [WIDTH-1:0] guess;
    logic             clear;
    logic [PTR_W:0]   count;
    logic             full;
    logic [PTR_W-1:0] guess_idx;
    logic             checking;
    logic             correct;
    logic             wrong;
    logic             win;
    logic             lose;

    modport slave (
        input  pattern_valid, pattern_in, start, guess_valid, guess, clear,
        output count, full, guess_idx, checking, correct, wrong, win, lose
    );

    modport master (
        output pattern_valid, pattern_in, start, guess_valid, guess, clear,
        input  count, full, guess_idx, checking, correct, wrong, win, lose
    );
endinterface

// File: rtl/pattern_checker.sv
// Captures generator patterns into a small buffer, then checks player guesses against them in order.
//
//   state | meaning
//   IDLE  | loading patterns, waiting for start
//   CHECK | comparing each guess against mem[rd_ptr]
//   WIN   | every stored pattern matched; hold until clear
//   LOSE  | a guess mismatched; rd_ptr keeps the failing index
module pattern_checker #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk_in,
    input  logic            rst,
    pattern_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, WIN, LOSE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             correct_q;
    logic             wrong_q;

    logic             full_w;
    logic             hit;
    logic             last;
    logic             do_write;
    logic             do_start;
    logic             do_hit;
    logic             do_miss;
    logic             do_clear;

    assign full_w = (count == (PTR_W+1)'(DEPTH));
    assign hit    = (bus.guess == mem[rd_ptr]);
    assign last   = ({1'b0, rd_ptr} == (count - 1'b1));

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        do_start  = 1'b0;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        do_clear  = 1'b0;
        case (state)
            IDLE: begin
                // start always suppresses a coincident write, even when start itself is ignored
                if (bus.start) begin
                    if (count != '0) begin
                        do_start  = 1'b1;
                        state_nxt = CHECK;
                    end
                end else if (bus.pattern_valid && !full_w) begin
                    do_write = 1'b1;
                end
            end
            CHECK: begin
                if (bus.guess_valid) begin
                    if (hit) begin
                        do_hit = 1'b1;
                        if (last) state_nxt = WIN;
                    end else begin
                        do_miss   = 1'b1;
                        state_nxt = LOSE;
                    end
                end
            end
            WIN, LOSE: begin
                if (bus.clear) begin
                    do_clear  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
        end else begin
            correct_q <= do_hit;
            wrong_q   <= do_miss;
            if (do_write) begin
                count <= count + 1'b1;
                if (wr_ptr != PTR_W'(DEPTH-1)) wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_start) rd_ptr <= '0;
            // guess_idx reads 0 in WIN, so the last hit rewinds the read pointer
            if (do_hit) rd_ptr <= last ? '0 : rd_ptr + 1'b1;
            if (do_clear) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_write) mem[wr_ptr] <= bus.pattern_in;
    end

    assign bus.count     = count;
    assign bus.full      = full_w;
    assign bus.guess_idx = rd_ptr;
    assign bus.checking  = (state == CHECK);
    assign bus.win       = (state == WIN);
    assign bus.lose      = (state == LOSE);
    assign bus.correct   = correct_q;
    assign bus.wrong     = wrong_q;
endmodule
